// File: rtl/capture_pkg.sv
// Shared types and constants for the ADC capture buffer.
package capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] TRIG_EXT   = 2'd0;
    localparam logic [1:0] TRIG_LEVEL = 2'd1;
    localparam logic [1:0] TRIG_FORCE = 2'd2;
    localparam logic [1:0] TRIG_NONE  = 2'd3;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned HALF_W = 16;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, registered read-first read port.
module capture_ram #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned WIDTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Separate read process returns the pre-write contents on a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/adc_capture.sv
// Triggered dual-channel capture: decimates ADC samples into a pre/post-trigger
// window in block RAM, frozen until the next arm.
module adc_capture
    import capture_pkg::*;
#(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEC_W  = 16
) (
    input  logic              adc_clk,
    input  logic              adc_rst,
    input  logic [DATA_W-1:0] adc_a_i,
    input  logic [DATA_W-1:0] adc_b_i,
    input  logic              arm_i,
    input  logic [1:0]        trig_src_i,
    input  logic              trig_i,
    input  logic [DATA_W-1:0] trig_level_i,
    input  logic [ADDR_W-1:0] pretrig_i,
    input  logic [DEC_W-1:0]  dec_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [31:0]       rd_data_o,
    output logic              rd_valid_o,
    output logic [2:0]        state_o,
    output logic [ADDR_W-1:0] trig_addr_o,
    output logic              done_o
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]        trig_addr_q, trig_addr_d;
    logic [ADDR_W:0]          cnt_q, cnt_d;
    logic [DEC_W-1:0]         dec_cnt_q, dec_cnt_d;
    logic                     done_q, done_d;
    logic                     pend_q, pend_d;
    logic                     have_prev_q, have_prev_d;
    logic signed [DATA_W-1:0] prev_a_q, prev_a_d;

    logic signed [DATA_W-1:0] cur_a, level;
    logic [DEC_W-1:0]         dec_max;
    logic [ADDR_W:0]          post_len;
    logic                     active, strobe, wr_en, hit;
    logic [WORD_W-1:0]        wr_word;

    assign cur_a    = adc_a_i;
    assign level    = trig_level_i;
    assign dec_max  = (dec_i == '0) ? '0 : dec_i - 1'b1;
    assign post_len = DEPTH - {1'b0, pretrig_i};
    assign active   = (state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST);
    assign strobe   = active && (dec_cnt_q == '0);
    assign wr_word  = {{(HALF_W-DATA_W){adc_b_i[DATA_W-1]}}, adc_b_i,
                       {(HALF_W-DATA_W){adc_a_i[DATA_W-1]}}, adc_a_i};

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        trig_addr_d = trig_addr_q;
        cnt_d       = cnt_q;
        dec_cnt_d   = dec_cnt_q;
        done_d      = done_q;
        pend_d      = pend_q;
        have_prev_d = have_prev_q;
        prev_a_d    = prev_a_q;
        wr_en       = 1'b0;
        hit         = 1'b0;

        if (active) begin
            dec_cnt_d = (dec_cnt_q >= dec_max) ? '0 : dec_cnt_q + 1'b1;
        end

        case (state_q)
            ST_PRE: begin
                if (pretrig_i == '0) begin
                    state_d = ST_ARMED;
                end else if (strobe) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == {1'b0, pretrig_i}) begin
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                    end
                end
            end
            ST_ARMED: begin
                if (trig_src_i == TRIG_EXT && trig_i) begin
                    pend_d = 1'b1;
                end
                if (strobe) begin
                    wr_en = 1'b1;
                    case (trig_src_i)
                        TRIG_EXT:   hit = pend_q || trig_i;
                        TRIG_LEVEL: hit = have_prev_q && (prev_a_q < level) && (cur_a >= level);
                        TRIG_FORCE: hit = 1'b1;
                        default:    hit = 1'b0;
                    endcase
                    if (hit) begin
                        trig_addr_d = wr_ptr_q;
                        pend_d      = 1'b0;
                        cnt_d       = {{ADDR_W{1'b0}}, 1'b1};
                        // With pretrig_i = DEPTH-1 the trigger sample is also the last one.
                        if (post_len == {{ADDR_W{1'b0}}, 1'b1}) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_POST;
                        end
                    end
                end
            end
            ST_POST: begin
                if (strobe) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == post_len) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (wr_en) begin
            wr_ptr_d    = wr_ptr_q + 1'b1;
            prev_a_d    = cur_a;
            have_prev_d = 1'b1;
        end

        // Arm overrides everything in flight, including a coincident trigger or write.
        if (arm_i) begin
            state_d     = ST_PRE;
            wr_ptr_d    = '0;
            cnt_d       = '0;
            dec_cnt_d   = '0;
            done_d      = 1'b0;
            pend_d      = 1'b0;
            have_prev_d = 1'b0;
            trig_addr_d = trig_addr_q;
            wr_en       = 1'b0;
        end
    end

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            trig_addr_q <= '0;
            cnt_q       <= '0;
            dec_cnt_q   <= '0;
            done_q      <= 1'b0;
            pend_q      <= 1'b0;
            have_prev_q <= 1'b0;
            prev_a_q    <= '0;
            rd_valid_o  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            trig_addr_q <= trig_addr_d;
            cnt_q       <= cnt_d;
            dec_cnt_q   <= dec_cnt_d;
            done_q      <= done_d;
            pend_q      <= pend_d;
            have_prev_q <= have_prev_d;
            prev_a_q    <= prev_a_d;
            rd_valid_o  <= rd_en_i;
        end
    end

    capture_ram #(
        .ADDR_W (ADDR_W),
        .WIDTH  (WORD_W)
    ) u_ram (
        .clk   (adc_clk),
        .rst   (adc_rst),
        .we    (wr_en && !adc_rst),
        .waddr (wr_ptr_q),
        .wdata (wr_word),
        .re    (rd_en_i),
        .raddr (rd_addr_i),
        .rdata (rd_data_o)
    );

    assign state_o     = state_q;
    assign trig_addr_o = trig_addr_q;
    assign done_o      = done_q;

endmodule

// File: doc/adc_capture.md
# adc_capture

Triggered dual-channel capture buffer sitting directly downstream of the ADC input path in the system wrapper: it takes the registered 14-bit channel A/B samples on the ADC clock, decimates them, and stores a pre-/post-trigger window in block RAM. The processing system reads the frozen window back through a simple address/enable read port. One capture per arm; the buffer stays frozen until re-armed.

## Interface
Parameters:
- DATA_W, 14, ADC sample width (two's complement)
- ADDR_W, 10, buffer address width; DEPTH = 2**ADDR_W samples
- DEC_W, 16, decimation factor width

Ports:
- adc_clk  in  1  sole clock, ADC sample clock
- adc_rst  in  1  synchronous reset, active-high
- adc_a_i  in  DATA_W  channel A sample, signed
- adc_b_i  in  DATA_W  channel B sample, signed
- arm_i  in  1  single-cycle pulse, starts/restarts a capture
- trig_src_i  in  2  0 = external, 1 = channel A rising level, 2 = force, 3 = reserved (never triggers)
- trig_i  in  1  external trigger pulse
- trig_level_i  in  DATA_W  signed level for source 1
- pretrig_i  in  ADDR_W  pre-trigger sample count, 0..DEPTH-1
- dec_i  in  DEC_W  decimation factor; 0 treated as 1
- rd_en_i  in  1  read request
- rd_addr_i  in  ADDR_W  read address
- rd_data_o  out  32  {sign-extended B[15:0], sign-extended A[15:0]}
- rd_valid_o  out  1  rd_data_o valid
- state_o  out  3  current state encoding
- trig_addr_o  out  ADDR_W  buffer address of the trigger sample
- done_o  out  1  capture complete, buffer frozen

## Operation
- States: IDLE(0), PRE(1), ARMED(2), POST(3), DONE(4).
- Reset: state IDLE; write pointer, sample counter, decimation counter, trig_addr_o, rd_data_o, rd_valid_o, done_o all 0. Buffer contents are not cleared.
- arm_i in any state: next state PRE; write pointer, sample count and decimation counter cleared; done_o cleared; pending trigger cleared.
- Decimation: counter runs 0..max(dec_i,1)-1 while in PRE/ARMED/POST. Strobe when counter = 0. First strobe on the first PRE cycle. dec_i is sampled continuously; a change takes effect at the next wrap.
- On each strobe: write {sext(B), sext(A)} at write pointer; pointer increments modulo DEPTH.
- PRE: counts written samples; when count reaches pretrig_i, go to ARMED on the same cycle as that write. pretrig_i = 0: leave PRE after the first cycle without writing.
- ARMED: keep writing (ring wrap allowed). Triggers:
  - src 0: trig_i latched as pending; the next strobe sample is the trigger sample.
  - src 1: on a strobe, trigger if prev_A < level and cur_A >= level. prev_A is the previously written A. No trigger on the first ARMED strobe unless a prev sample exists from PRE.
  - src 2: the first ARMED strobe is the trigger sample.
  - On the trigger sample: trig_addr_o <= its address; state becomes POST.
- Triggers in IDLE, PRE, POST and DONE are ignored; a trig_i pulse outside ARMED is not latched.
- POST: the trigger sample counts as post sample 1. After DEPTH - pretrig_i post samples, the state is DONE and done_o = 1. Buffer then holds pretrig_i samples before the trigger. The oldest sample is at trig_addr_o - pretrig_i (mod DEPTH).
- DONE: no writes; waits for arm_i.
- Read: allowed in every state; read-first on an address collision with a concurrent write.

## Timing
- Read latency 1: rd_en_i at cycle n gives rd_valid_o and rd_data_o at n+1. rd_valid_o is low otherwise, and rd_data_o holds its last value.
- Trigger sample written in the same cycle as its detecting strobe.
- done_o rises the cycle after the final post write.
- State transitions are visible on state_o one cycle after their cause.
- arm_i and a trigger in the same cycle: arm wins; the trigger is discarded.
- rd_en_i is back-to-back capable; one read per cycle.

## Structure
- Package capture_pkg: state encodings, trigger-source constants, data word packing width (32).
- Sub-module capture_ram: simple dual-port RAM, write port plus registered read-first read port, parameterised on ADDR_W and width 32, inferring BRAM.
- Top holds the FSM, decimator, trigger detection and pointers.

## Test plan
- Reset mid-POST (adc_rst for 1 cycle) -> state_o=0, done_o=0, rd_valid_o=0 next cycle; no further writes.
- dec_i=1, pretrig_i=100, src 2, A ramp 0,1,2… -> done_o after 1024 post-arm samples. trig_addr_o=100, buffer[100]=A value 100, buffer[99]=99.
- src 1, level=500, A ramp by 7 from 0 -> trigger sample A=504. buffer[trig_addr_o-1] A=497.
- dec_i=4, src 0, trig_i pulsed once in PRE and once in ARMED -> only the ARMED pulse triggers. Consecutive buffer entries differ by 4 ramp steps.
- dec_i=0 behaves as dec_i=1 -> identical capture to the dec_i=1 case. B=-3 reads back as 0xFFFD in the upper half.
- arm_i during POST -> state PRE and done_o stays 0. rd_en_i at addr 5 gives rd_valid_o one cycle later, with read-first data on a write collision.
